// File: rtl/minimips_pkg.sv
// Shared definitions for the immediate narrowing path: field widths, buffer
// states and constant helpers for the signed range of an N-bit field.
package minimips_pkg;

    localparam int IMM_W  = 6;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    function automatic longint imm_min(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    function automatic longint imm_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/sign_narrow_fit.sv
// Combinational fit check: packs a signed IN_W value into OUT_W bits,
// clamping or truncating when the value does not survive sign extension.
module narrow_fit
    import minimips_pkg::*;
#(
    parameter int IN_W     = WORD_W,
    parameter int OUT_W    = IMM_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic [IN_W-1:0]  in_data,
    output logic [OUT_W-1:0] out_data,
    output logic             ovf
);

    localparam logic [OUT_W-1:0] SAT_MIN = OUT_W'(imm_min(OUT_W));
    localparam logic [OUT_W-1:0] SAT_MAX = OUT_W'(imm_max(OUT_W));

    // The value fits when every bit from the field sign bit upward agrees.
    logic [IN_W-OUT_W:0] upper;
    logic                fits;

    assign upper = in_data[IN_W-1:OUT_W-1];
    assign fits  = (&upper) | ~(|upper);

    always_comb begin
        out_data = in_data[OUT_W-1:0];
        ovf      = ~fits;
        if (!fits && SATURATE) begin
            out_data = in_data[IN_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/sign_narrow.sv
// Narrows signed words to a short immediate field behind a 2-entry
// valid/ready output buffer, counting accepted overflowing values.
module sign_narrow
    import minimips_pkg::*;
#(
    parameter int IN_W     = WORD_W,
    parameter int OUT_W    = IMM_W,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clear_count,
    output logic [CNT_W-1:0] ovf_count
);

    logic [OUT_W-1:0] fit_data;
    logic             fit_ovf;

    narrow_fit #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .SATURATE(SATURATE)
    ) u_fit (
        .in_data (in_data),
        .out_data(fit_data),
        .ovf     (fit_ovf)
    );

    buf_state_e       state_q, state_d;
    logic [OUT_W-1:0] head_data_q, head_data_d;
    logic             head_ovf_q, head_ovf_d;
    logic [OUT_W-1:0] tail_data_q, tail_data_d;
    logic             tail_ovf_q, tail_ovf_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, pop;

    assign accept = in_valid && in_ready_q;
    assign pop    = out_valid && out_ready;

    // The head register drives out_data directly, so the second entry only
    // ever shifts into the head on a pop from FULL.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_ovf_d  = head_ovf_q;
        tail_data_d = tail_data_q;
        tail_ovf_d  = tail_ovf_q;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    head_data_d = fit_data;
                    head_ovf_d  = fit_ovf;
                    state_d     = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (accept && !pop) begin
                    tail_data_d = fit_data;
                    tail_ovf_d  = fit_ovf;
                    state_d     = BUF_FULL;
                end else if (!accept && pop) begin
                    state_d     = BUF_EMPTY;
                end else if (accept && pop) begin
                    head_data_d = fit_data;
                    head_ovf_d  = fit_ovf;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_ovf_d  = tail_ovf_q;
                    state_d     = BUF_ONE;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
        in_ready_d = (state_d != BUF_FULL);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (accept && fit_ovf && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= BUF_EMPTY;
            head_data_q <= '0;
            head_ovf_q  <= 1'b0;
            tail_data_q <= '0;
            tail_ovf_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_ovf_q  <= head_ovf_d;
            tail_data_q <= tail_data_d;
            tail_ovf_q  <= tail_ovf_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = head_data_q;
    assign out_ovf   = head_ovf_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_sign_narrow.sv
// Bench for sign_narrow: a saturating instance (2-bit counter) and a truncating
// instance share stimulus and are checked against a queue-based model.
module tb_sign_narrow;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        clear_count;

    logic        in_ready_s, out_valid_s, out_ovf_s;
    logic [5:0]  out_data_s;
    logic [1:0]  ovf_count_s;
    logic        in_ready_t, out_valid_t, out_ovf_t;
    logic [5:0]  out_data_t;
    logic [15:0] ovf_count_t;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sign_narrow #(.IN_W(32), .OUT_W(6), .SATURATE(1'b1), .CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_ovf(out_ovf_s), .clear_count(clear_count),
        .ovf_count(ovf_count_s)
    );

    sign_narrow #(.IN_W(32), .OUT_W(6), .SATURATE(1'b0), .CNT_W(16)) dut_t (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_data(in_data), .out_valid(out_valid_t), .out_ready(out_ready),
        .out_data(out_data_t), .out_ovf(out_ovf_t), .clear_count(clear_count),
        .ovf_count(ovf_count_t)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model result {ovf, data}: decided from the numeric range of the field.
    function automatic logic [6:0] model_narrow(input logic [31:0] v, input bit sat);
        longint s;
        logic [5:0] low;
        s   = longint'($signed(v));
        low = v[5:0];
        if (s >= -32 && s <= 31) return {1'b0, low};
        if (sat) return {1'b1, (s < 0) ? 6'b100000 : 6'b011111};
        return {1'b1, low};
    endfunction

    logic [6:0] qs[$];
    logic [6:0] qt[$];
    int         cs, ct;
    bit         m_rdy, m_acc, m_pop;
    logic [6:0] es, et;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            qs.delete(); qt.delete();
            cs = 0; ct = 0; m_rdy = 0;
        end else begin
            m_acc = in_valid && m_rdy;
            m_pop = (qs.size() > 0) && out_ready;
            es = model_narrow(in_data, 1'b1);
            et = model_narrow(in_data, 1'b0);
            if (m_pop) begin
                void'(qs.pop_front());
                void'(qt.pop_front());
            end
            if (m_acc) begin
                qs.push_back(es);
                qt.push_back(et);
            end
            if (clear_count) begin
                cs = 0; ct = 0;
            end else if (m_acc) begin
                if (es[6] && cs < 3) cs++;
                if (et[6] && ct < 65535) ct++;
            end
            m_rdy = (qs.size() < 2);
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (!reset_n) begin
            chk("rst_valid_s", 32'(out_valid_s), 32'd0);
            chk("rst_ready_s", 32'(in_ready_s), 32'd0);
            chk("rst_data_s", 32'(out_data_s), 32'd0);
            chk("rst_cnt_t", 32'(ovf_count_t), 32'd0);
        end else begin
            chk("mdl_valid_s", 32'(out_valid_s), 32'(qs.size() > 0));
            chk("mdl_valid_t", 32'(out_valid_t), 32'(qt.size() > 0));
            chk("mdl_ready_s", 32'(in_ready_s), 32'(m_rdy));
            chk("mdl_ready_t", 32'(in_ready_t), 32'(m_rdy));
            chk("mdl_cnt_s", 32'(ovf_count_s), 32'(cs));
            chk("mdl_cnt_t", 32'(ovf_count_t), 32'(ct));
            if (qs.size() > 0) chk("mdl_head_s", 32'({out_ovf_s, out_data_s}), 32'(qs[0]));
            if (qt.size() > 0) chk("mdl_head_t", 32'({out_ovf_t, out_data_t}), 32'(qt[0]));
        end
    end

    task automatic send_check(input logic [31:0] v, input logic [5:0] ds, input bit os,
                              input logic [5:0] dt, input bit ot);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'hDEADBEEF;
        chk("lit_valid_s", 32'(out_valid_s), 32'd1);
        chk("lit_data_s", 32'(out_data_s), 32'(ds));
        chk("lit_ovf_s", 32'(out_ovf_s), 32'(os));
        chk("lit_data_t", 32'(out_data_t), 32'(dt));
        chk("lit_ovf_t", 32'(out_ovf_t), 32'(ot));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_cnt [5];
        exp_cnt = '{1, 2, 3, 3, 3};
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clear_count = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 32'(out_valid_s), 32'd0);
        chk("reset_in_ready", 32'(in_ready_s), 32'd0);
        chk("reset_cnt", 32'(ovf_count_s), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", 32'(in_ready_s), 32'd1);

        // Fitting values, boundaries and far overflow on both instances.
        send_check(32'hFFFFFFFF, 6'b111111, 0, 6'b111111, 0);
        send_check(32'h00000015, 6'b010101, 0, 6'b010101, 0);
        send_check(32'h0000001F, 6'b011111, 0, 6'b011111, 0);
        send_check(32'hFFFFFFE0, 6'b100000, 0, 6'b100000, 0);
        send_check(32'h00000020, 6'b011111, 1, 6'b100000, 1);
        send_check(32'hFFFFFFDF, 6'b100000, 1, 6'b011111, 1);
        send_check(32'h7FFFFFFF, 6'b011111, 1, 6'b111111, 1);
        send_check(32'h80000000, 6'b100000, 1, 6'b000000, 1);
        chk("cnt_sat_s", 32'(ovf_count_s), 32'd3);
        chk("cnt_t", 32'(ovf_count_t), 32'd4);

        // Counter: clear, then 5 overflowing accepts against a 2-bit counter.
        @(negedge clk); clear_count = 1'b1;
        @(negedge clk); clear_count = 1'b0;
        chk("cnt_clear_s", 32'(ovf_count_s), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send_check(32'h00000100, 6'b011111, 1, 6'b000000, 1);
            chk("cnt_step_s", 32'(ovf_count_s), 32'(exp_cnt[i]));
        end
        chk("cnt_step_t", 32'(ovf_count_t), 32'd5);
        @(negedge clk); in_valid = 1'b1; in_data = 32'h00001000; clear_count = 1'b1;
        @(negedge clk); in_valid = 1'b0; clear_count = 1'b0;
        chk("cnt_clr_prio_s", 32'(ovf_count_s), 32'd0);
        chk("cnt_clr_prio_t", 32'(ovf_count_t), 32'd0);
        @(negedge clk);

        // Continuous stream: push and pop every cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("stream_head", 32'(out_data_s), 32'(i));
                chk("stream_ready", 32'(in_ready_s), 32'd1);
            end
            in_valid = 1'b1;
            in_data  = 32'(i + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream_last", 32'(out_data_s), 32'd8);

        // Backpressure: two accepts fill the buffer, the third waits.
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd1;
        @(negedge clk); chk("bp_ready1", 32'(in_ready_s), 32'd1); in_data = 32'd2;
        @(negedge clk); chk("bp_full", 32'(in_ready_s), 32'd0); in_data = 32'd3;
        chk("bp_head1", 32'(out_data_s), 32'd1);
        @(negedge clk); chk("bp_hold_ready", 32'(in_ready_s), 32'd0);
        chk("bp_hold_head", 32'(out_data_s), 32'd1);
        out_ready = 1'b1;
        @(negedge clk); chk("bp_head2", 32'(out_data_s), 32'd2);
        chk("bp_ready2", 32'(in_ready_s), 32'd1);
        @(negedge clk); chk("bp_head3", 32'(out_data_s), 32'd3); in_valid = 1'b0;
        @(negedge clk); chk("bp_drained", 32'(out_valid_s), 32'd0);

        // Reset while FULL with overflow entries counted.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h40;
        @(negedge clk); in_data = 32'h41;
        @(negedge clk); in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready_s), 32'd0);
        chk("pre_rst_cnt", 32'(ovf_count_s), 32'd2);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid_s), 32'd0);
        chk("midrst_cnt", 32'(ovf_count_s), 32'd0);
        chk("midrst_data", 32'(out_data_t), 32'd0);
        chk("midrst_ready", 32'(in_ready_t), 32'd0);
        out_ready = 1'b1;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_ready", 32'(in_ready_s), 32'd1);
        chk("after_rst_valid", 32'(out_valid_s), 32'd0);
        repeat (2) @(negedge clk);
        chk("no_stale_s", 32'(out_valid_s), 32'd0);
        chk("no_stale_t", 32'(out_valid_t), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
